adc_scan_ctrl: RTL and testbench

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_scan_pkg.sv | 16 +
 rtl/adc_scan_sched.sv | 39 +++
 rtl/adc_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan controller.
package adc_scan_pkg;

  localparam int unsigned ADC_BITS = 16;
  localparam int unsigned NUM_CH   = 7;
  localparam int unsigned CH_W     = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StConv,
    StRead,
    StWait
  } state_e;

endpackage

// File: rtl/adc_scan_sched.sv
// Channel scheduler: picks the next enabled channel above the current one,
// wrapping to the lowest enabled channel, and flags the wrap.
module adc_scan_sched
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CH_W-1:0]   cur_ch,
  input  logic              cur_valid,
  output logic              any_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              wrap
);

  logic [CH_W-1:0] lowest;
  logic [CH_W-1:0] above;
  logic            above_found;

  always_comb begin
    lowest      = '0;
    above       = '0;
    above_found = 1'b0;
    any_ch      = 1'b0;
    // Descending scan so the last hit is the lowest qualifying bit.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lowest = CH_W'(i);
        any_ch = 1'b1;
        if (CH_W'(i) > cur_ch) begin
          above       = CH_W'(i);
          above_found = 1'b1;
        end
      end
    end
    // Before the first selection the pointer is meaningless: start at the lowest bit.
    next_ch = (cur_valid && above_found) ? above : lowest;
    wrap    = cur_valid && !above_found;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC scan sequencer: settle, convert, serial read, slot padding.
// Optional build macro ADC_SCAN_TEST_PATTERN_EN adds an internal ramp source selected by test_mode.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNV_CYC    = 4
) (
  input  logic                sys_clk_adc,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [7:0]          conv_period,
  input  logic                test_mode,
  input  logic                ADC_SDO,
  output logic                CNV,
  output logic                ADC_SCK,
  output logic [NUM_CH-1:0]   CH_en,
  output logic [ADC_BITS-1:0] sample_data,
  output logic [CH_W-1:0]     sample_ch,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow,
  output logic [7:0]          frame_count,
  output logic                busy
);

  localparam int unsigned MIN_SLOT   = SETTLE_CYC + CNV_CYC + 33;
  localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] CONV_END   = 16'(SETTLE_CYC + CNV_CYC - 1);
  localparam logic [15:0] MIN_LAST   = 16'(MIN_SLOT - 1);

  state_e              state_q, state_d;
  logic [15:0]         slot_cnt_q;
  logic [15:0]         slot_last;
  logic [4:0]          rd_cnt_q;
  logic [ADC_BITS-2:0] shreg_q;
  logic [ADC_BITS-1:0] captured;
  logic [CH_W-1:0]     cur_ch_q;
  logic                cur_valid_q;
  logic [7:0]          frame_count_q;
  logic [ADC_BITS-1:0] sample_data_q;
  logic [CH_W-1:0]     sample_ch_q;
  logic                sample_valid_q;
  logic                overflow_q;
  logic                enable_q;
  logic                select;
  logic                done;
  logic                shift_en;
  logic                shift_bit;
  logic                any_ch;
  logic [CH_W-1:0]     next_ch;
  logic                wrap;

  adc_scan_sched u_sched (
    .ch_mask   (ch_mask),
    .cur_ch    (cur_ch_q),
    .cur_valid (cur_valid_q),
    .any_ch    (any_ch),
    .next_ch   (next_ch),
    .wrap      (wrap)
  );

  // Last slot cycle index: max(conv_period, MIN_SLOT) - 1.
  assign slot_last = ({8'd0, conv_period} > MIN_LAST) ? ({8'd0, conv_period} - 16'd1) : MIN_LAST;

  always_comb begin
    state_d = state_q;
    select  = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_ch) begin
            state_d = StSettle;
            select  = 1'b1;
          end
        end
        StSettle: if (slot_cnt_q == SETTLE_END) state_d = StConv;
        StConv:   if (slot_cnt_q == CONV_END) state_d = StRead;
        StRead:   if (rd_cnt_q == 5'd31) state_d = StWait;
        StWait: begin
          if (slot_cnt_q >= slot_last) begin
            if (any_ch) begin
              state_d = StSettle;
              select  = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // SCK is low on even read cycles, so odd cycles hold the rising edge.
  assign shift_en = (state_q == StRead) && rd_cnt_q[0];
  assign done     = enable && (state_q == StRead) && (rd_cnt_q == 5'd31);
  assign captured = {shreg_q, shift_bit};

`ifdef ADC_SCAN_TEST_PATTERN_EN
  logic [ADC_BITS-1:0] ramp_q;

  always_ff @(posedge sys_clk_adc or posedge rst) begin
    if (rst) begin
      ramp_q <= '0;
    end else if (done) begin
      ramp_q <= ramp_q + 16'd1;
    end
  end

  assign shift_bit = test_mode ? ramp_q[4'd15 - rd_cnt_q[4:1]] : ADC_SDO;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign shift_bit        = ADC_SDO;
`endif

  always_ff @(posedge sys_clk_adc or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      slot_cnt_q     <= '0;
      rd_cnt_q       <= '0;
      shreg_q        <= '0;
      cur_ch_q       <= '0;
      cur_valid_q    <= 1'b0;
      frame_count_q  <= '0;
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      enable_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable;
      if (select) begin
        slot_cnt_q  <= '0;
        cur_ch_q    <= next_ch;
        cur_valid_q <= 1'b1;
        if (wrap) frame_count_q <= frame_count_q + 8'd1;
      end else if (state_q != StIdle) begin
        slot_cnt_q <= slot_cnt_q + 16'd1;
      end
      rd_cnt_q <= (state_q == StRead && state_d == StRead) ? rd_cnt_q + 5'd1 : '0;
      if (shift_en) shreg_q <= captured[ADC_BITS-2:0];
      if (done) begin
        if (sample_valid_q && !sample_ready) begin
          overflow_q <= 1'b1;
        end else begin
          sample_data_q  <= captured;
          sample_ch_q    <= cur_ch_q;
          sample_valid_q <= 1'b1;
        end
      end else if (sample_valid_q && sample_ready) begin
        sample_valid_q <= 1'b0;
      end
      if (enable && !enable_q) overflow_q <= 1'b0;
    end
  end

  assign CNV          = (state_q == StConv);
  assign ADC_SCK      = (state_q == StRead) ? rd_cnt_q[0] : 1'b1;
  assign CH_en        = (state_q != StIdle) ? (NUM_CH'(1) << cur_ch_q) : '0;
  assign busy         = (state_q != StIdle);
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign overflow     = overflow_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl; expectations follow ADC_SCAN_TEST_PATTERN_EN when defined.
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [6:0]  ch_mask = '0;
  logic [7:0]  conv_period = '0;
  logic        test_mode = 1'b0;
  logic        ADC_SDO = 1'b0;
  logic        sample_ready = 1'b0;
  logic        CNV;
  logic        ADC_SCK;
  logic [6:0]  CH_en;
  logic [15:0] sample_data;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        overflow;
  logic [7:0]  frame_count;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  ch;
    int          fc;  // -1: frame_count not checked
  } exp_t;

  exp_t        sb[$];
  int          hs_times[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] sdo_pat = 16'h0000;
  int          bitpos = 0;

  adc_scan_ctrl dut (
    .sys_clk_adc  (clk),
    .rst          (rst),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .conv_period  (conv_period),
    .test_mode    (test_mode),
    .ADC_SDO      (ADC_SDO),
    .CNV          (CNV),
    .ADC_SCK      (ADC_SCK),
    .CH_en        (CH_en),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] ch, input int fc);
    exp_t e;
    e.data = d;
    e.ch   = ch;
    e.fc   = fc;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b0; test_mode = 1'b0;
    ch_mask = '0; conv_period = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d samples pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_cnv(input logic level, input string name);
    int n;
    n = 0;
    while (CNV !== level && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, CNV, level);
  endtask

  // ADC model: reload on CNV rise, present next bit MSB-first on each SCK fall.
  initial forever begin
    @(posedge CNV or negedge ADC_SCK);
    if (CNV === 1'b1 && ADC_SCK === 1'b1) begin
      bitpos = 0;
    end else if (ADC_SCK === 1'b0 && bitpos < 16) begin
      ADC_SDO = sdo_pat[15 - bitpos];
      bitpos++;
    end
  end

  // Monitor: every accepted sample is checked against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sample_valid && sample_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got ch%0d data %0h expected none", sample_ch,
                   sample_data);
        end else begin
          e = sb.pop_front();
          chk("sample_data", sample_data, e.data);
          chk("sample_ch", sample_ch, e.ch);
          if (e.fc >= 0) chk("frame_count", frame_count, e.fc);
          hs_times.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int   len, cnv_n, rises;
    logic prev_sck, prev_cnv, seen;

    repeat (2) @(negedge clk);
    chk("rst_cnv", CNV, 0);
    chk("rst_sck", ADC_SCK, 1);
    chk("rst_ch_en", CH_en, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_ch", sample_ch, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two channels, 50-cycle slots.
    ch_mask = 7'b0000101; conv_period = 8'd50; sample_ready = 1'b1; sdo_pat = 16'hA5A5;
    hs_times.delete();
    push(16'hA5A5, 3'd0, 0);
    push(16'hA5A5, 3'd2, 0);
    push(16'hA5A5, 3'd0, 1);
    push(16'hA5A5, 3'd2, 1);
    enable = 1'b1;
    wait_drain(300, "scan");
    @(posedge clk);
    #1 enable = 1'b0;
    if (hs_times.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("scan_interval", hs_times[i] - hs_times[i-1], 50);
    end else begin
      chk("scan_sample_count", hs_times.size(), 4);
    end
    @(posedge clk);
    @(negedge clk);
    chk("disable_busy", busy, 0);
    chk("disable_ch_en", CH_en, 0);

    // Minimum slot: 41 cycles, 4 CNV cycles, 16 SCK rising edges.
    do_reset();
    ch_mask = 7'b0000010; conv_period = 8'd10; sample_ready = 1'b1; sdo_pat = 16'h1234;
    push(16'h1234, 3'd1, 0);
    push(16'h1234, 3'd1, 1);
    enable = 1'b1;
    wait_cnv(1'b1, "min_cnv_seen");
    len = 0; cnv_n = 0; rises = 0; prev_sck = 1'b1; prev_cnv = 1'b0;
    while (len < 100) begin
      if (CNV && !prev_cnv && len > 0) break;
      if (CNV) cnv_n++;
      if (ADC_SCK && !prev_sck) rises++;
      prev_sck = ADC_SCK;
      prev_cnv = CNV;
      len++;
      @(negedge clk);
    end
    chk("min_slot_len", len, 41);
    chk("min_cnv_cycles", cnv_n, 4);
    chk("min_sck_rises", rises, 16);
    wait_drain(120, "min");
    @(posedge clk);
    #1 enable = 1'b0;

    // Backpressure: first sample held, second dropped, overflow sticky.
    do_reset();
    ch_mask = 7'b0000011; conv_period = 8'd0; sample_ready = 1'b0; sdo_pat = 16'h3C0F;
    push(16'h3C0F, 3'd0, -1);
    enable = 1'b1;
    repeat (100) @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("ovf_held_valid", sample_valid, 1);
    chk("ovf_held_ch", sample_ch, 0);
    chk("ovf_held_data", sample_data, 16'h3C0F);
    chk("ovf_pending", sb.size(), 1);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("ovf_valid_after_disable", sample_valid, 1);
    chk("ovf_idle_busy", busy, 0);
    chk("ovf_sticky", overflow, 1);
    @(posedge clk);
    #1 sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovf_accepted", sample_valid, 0);
    chk("ovf_drained", sb.size(), 0);
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);

    // Abort during READ.
    do_reset();
    ch_mask = 7'b0000100; conv_period = 8'd0; sample_ready = 1'b1; sdo_pat = 16'hFFFF;
    enable = 1'b1;
    wait_cnv(1'b1, "abort_cnv_high");
    wait_cnv(1'b0, "abort_cnv_low");
    chk("abort_read_sck_low", ADC_SCK, 0);
    chk("abort_busy", busy, 1);
    chk("abort_ch_en", CH_en, 7'b0000100);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sck_idle", ADC_SCK, 1);
    chk("abort_ch_en_off", CH_en, 0);
    chk("abort_cnv_off", CNV, 0);
    chk("abort_idle", busy, 0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    chk("abort_no_sample", seen, 0);

    // Single channel 6: frame_count advances every slot and wraps 255 -> 0.
    do_reset();
    ch_mask = 7'b1000000; conv_period = 8'd0; sample_ready = 1'b1; sdo_pat = 16'hC35A;
    for (int k = 1; k <= 257; k++) push(16'hC35A, 3'd6, (k - 1) % 256);
    enable = 1'b1;
    wait_drain(257 * 41 + 100, "single");
    @(posedge clk);
    #1 enable = 1'b0;

    // Test pattern source.
    do_reset();
    ch_mask = 7'b0000001; conv_period = 8'd0; sample_ready = 1'b1; sdo_pat = 16'hA5A5;
    test_mode = 1'b1;
`ifdef ADC_SCAN_TEST_PATTERN_EN
    push(16'h0000, 3'd0, 0);
    push(16'h0001, 3'd0, 1);
    push(16'h0002, 3'd0, 2);
`else
    push(16'hA5A5, 3'd0, 0);
    push(16'hA5A5, 3'd0, 1);
    push(16'hA5A5, 3'd0, 2);
`endif
    enable = 1'b1;
    wait_drain(200, "pattern");
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
